// File: rtl/seq_divider_32bit.sv
// Unsigned 32-bit restoring divider: one quotient bit per clock over 32 iterations.
// The trial subtraction is P' - D, formed as P' + ~D + 1 on a 32-bit ripple-carry adder.

module RCA_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[32];
endmodule

module seq_divider_32bit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  // Between iterations the top bit of P is always 0, so only the shifted P' carries bit 32.
  logic [WIDTH-1:0] p_q, p_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH-1:0] d_inv;
  logic [WIDTH-1:0] trial;
  logic             trial_cout;
  logic             sub_ok;
  logic [WIDTH-1:0] p_iter;
  logic [WIDTH-1:0] q_iter;

  assign p_shift = {p_q, q_q[WIDTH-1]};
  assign d_inv   = ~d_q;

  RCA_32bit u_rca (
    .a    (p_shift[WIDTH-1:0]),
    .b    (d_inv),
    .cin  (1'b1),
    .sum  (trial),
    .cout (trial_cout)
  );

  // Cout=1 means P'[31:0] >= D; P'[32]=1 means P' exceeds any 32-bit divisor.
  assign sub_ok = p_shift[WIDTH] | trial_cout;
  assign p_iter = sub_ok ? trial : p_shift[WIDTH-1:0];
  assign q_iter = {q_q[WIDTH-2:0], sub_ok};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    p_d     = p_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          p_d     = '0;
          count_d = '0;
          dbz_d   = 1'b0;
          if (divisor == '0) begin
            state_d = ST_DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        p_d     = p_iter;
        q_d     = q_iter;
        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          quot_d  = q_iter;
          rem_d   = p_iter;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      d_q     <= '0;
      p_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      p_q     <= p_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_32bit.sv
// Directed bench for seq_divider_32bit: latency, results, divide-by-zero, ignored start,
// mid-operation reset, and a short random sweep against the / and % operators.

module tb_seq_divider_32bit;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks;
  int n_fail;

  seq_divider_32bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every task starts and ends 1 time unit after a rising edge.
  // run_div: start edge E0, then count edges until done is seen (bounded), then one more edge.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int poke_at,
                         output int lat, output logic [31:0] rq, output logic [31:0] rr,
                         output logic rdbz, output logic post_done, output logic post_busy);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == poke_at) begin
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    rq   = quotient;
    rr   = remainder;
    rdbz = div_by_zero;
    @(posedge clk); #1;
    post_done = done;
    post_busy = busy;
    $display("div %0d / %0d -> q=%0d r=%0d dbz=%0b latency=%0d", a, b, rq, rr, rdbz, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_r: got %h expected 0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] q, r; logic z, pd, pb;
    run_div(32'd100, 32'd7, -1, lat, q, r, z, pd, pb);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL basic_latency: got %0d expected 32", lat); end
    n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL basic_q: got %0d expected 14", q); end
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL basic_r: got %0d expected 2", r); end
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b expected 0", z); end
    n_checks++; if (pd !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", pd); end
    n_checks++; if (pb !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", pb); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_hold_q: got %0d expected 14", quotient); end
    @(posedge clk); #1;
  endtask

  task automatic test_edges();
    int lat; logic [31:0] q, r; logic z, pd, pb;
    run_div(32'hFFFF_FFFF, 32'h8000_0000, -1, lat, q, r, z, pd, pb);
    n_checks++; if (q !== 32'd1) begin n_fail++; $display("FAIL wide_q: got %h expected 00000001", q); end
    n_checks++; if (r !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL wide_r: got %h expected 7fffffff", r); end
    run_div(32'hFFFF_FFFF, 32'd1, -1, lat, q, r, z, pd, pb);
    n_checks++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div1_q: got %h expected ffffffff", q); end
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL div1_r: got %h expected 0", r); end
    run_div(32'd3, 32'd10, -1, lat, q, r, z, pd, pb);
    n_checks++; if (q !== 32'd0) begin n_fail++; $display("FAIL small_q: got %0d expected 0", q); end
    n_checks++; if (r !== 32'd3) begin n_fail++; $display("FAIL small_r: got %0d expected 3", r); end
    run_div(32'd0, 32'd5, -1, lat, q, r, z, pd, pb);
    n_checks++; if (q !== 32'd0) begin n_fail++; $display("FAIL zero_dividend_q: got %0d expected 0", q); end
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL zero_dividend_r: got %0d expected 0", r); end
  endtask

  task automatic test_div_by_zero();
    int lat; logic [31:0] q, r; logic z, pd, pb;
    run_div(32'd5, 32'd0, -1, lat, q, r, z, pd, pb);
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL dbz_latency: got %0d expected 0", lat); end
    n_checks++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_q: got %h expected ffffffff", q); end
    n_checks++; if (r !== 32'd5) begin n_fail++; $display("FAIL dbz_r: got %0d expected 5", r); end
    n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b expected 1", z); end
    n_checks++; if (pd !== 1'b0) begin n_fail++; $display("FAIL dbz_done_pulse: got %b expected 0", pd); end
    run_div(32'd9, 32'd3, -1, lat, q, r, z, pd, pb);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL after_dbz_latency: got %0d expected 32", lat); end
    n_checks++; if (q !== 32'd3) begin n_fail++; $display("FAIL after_dbz_q: got %0d expected 3", q); end
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL after_dbz_flag: got %b expected 0", z); end
  endtask

  task automatic test_start_ignored();
    int lat; logic [31:0] q, r; logic z, pd, pb;
    run_div(32'd100, 32'd7, 5, lat, q, r, z, pd, pb);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 32", lat); end
    n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL ignore_q: got %0d expected 14", q); end
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL ignore_r: got %0d expected 2", r); end
  endtask

  task automatic test_reset_mid();
    int lat; int n_done; logic [31:0] q, r; logic z, pd, pb;
    dividend = 32'd123456;
    divisor  = 32'd789;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL midrst_q: got %0d expected 0", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL midrst_r: got %0d expected 0", remainder); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", n_done); end
    run_div(32'd1000, 32'd33, -1, lat, q, r, z, pd, pb);
    n_checks++; if (q !== 32'd30) begin n_fail++; $display("FAIL midrst_next_q: got %0d expected 30", q); end
    n_checks++; if (r !== 32'd10) begin n_fail++; $display("FAIL midrst_next_r: got %0d expected 10", r); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] q, r, a, b, eq, er; logic z, pd, pb;
    for (int i = 0; i < 100; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(31, 0);
      eq = (b == 0) ? 32'hFFFF_FFFF : a / b;
      er = (b == 0) ? a : a % b;
      run_div(a, b, -1, lat, q, r, z, pd, pb);
      n_checks++;
      if (q !== eq || r !== er || z !== (b == 0) || pd !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d: %h/%h got q=%h r=%h dbz=%b post_done=%b expected q=%h r=%h",
                 i, a, b, q, r, z, pd, eq, er);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_edges();
    test_div_by_zero();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
